// File: rtl/parking_keypad_entry.sv
// rtl/parking_keypad_entry.sv - two-digit keypad entry with debounce; optional entry timeout under `PARKING_KEYPAD_TIMEOUT_EN
module parking_keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_press,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       pw_ready,
  output logic [1:0] digit_cnt,
  output logic       key_overflow
);

  // A debounce depth below 1 makes no sense; treat it as 1.
  localparam int DB_CYC = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int DCW    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t     state;
  logic       press_s1, press_s2;
  logic [1:0] code_s1, code_s2;
  logic       db_level, db_level_q;
  logic [DCW-1:0] db_cnt;
  logic       press_evt;
  logic       tmo_hit;

  // Two-flop synchronizers for the raw keypad strobe and code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_s1 <= 1'b0;
      press_s2 <= 1'b0;
      code_s1  <= 2'd0;
      code_s2  <= 2'd0;
    end else begin
      press_s1 <= key_press;
      press_s2 <= press_s1;
      code_s1  <= key_code;
      code_s2  <= code_s1;
    end
  end

  // Debounce: the level follows the synchronized strobe only after it has differed for DB_CYC cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_level_q <= db_level;
      if (press_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= press_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Only a rising debounced level is a press; releases are silent.
  assign press_evt = db_level & ~db_level_q;

`ifdef PARKING_KEYPAD_TIMEOUT_EN
  localparam int TO_CYC = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int TCW    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'(TO_CYC - 1);

  logic [TCW-1:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TO_LAST);

  // Idle counter for a partial or complete entry; restarts whenever a digit is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || key_clear || tmo_hit || (press_evt && state != READY)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Entry FSM with registered outputs; clear/timeout win over a same-cycle press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      password_1   <= 2'd0;
      password_2   <= 2'd0;
      pw_ready     <= 1'b0;
      digit_cnt    <= 2'd0;
      key_overflow <= 1'b0;
    end else begin
      key_overflow <= 1'b0;
      if (key_clear || tmo_hit) begin
        state      <= IDLE;
        password_1 <= 2'd0;
        password_2 <= 2'd0;
        pw_ready   <= 1'b0;
        digit_cnt  <= 2'd0;
      end else if (press_evt) begin
        case (state)
          IDLE: begin
            password_1 <= code_s2;
            digit_cnt  <= 2'd1;
            state      <= GOT1;
          end
          GOT1: begin
            password_2 <= code_s2;
            digit_cnt  <= 2'd2;
            pw_ready   <= 1'b1;
            state      <= READY;
          end
          default: begin
            key_overflow <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_keypad_entry.sv
// tb/tb_parking_keypad_entry.sv - scoreboard bench for parking_keypad_entry
module tb_parking_keypad_entry;

  localparam int DB  = 4;
  localparam int TO  = 50;
  localparam int LAT = DB + 2;

  logic       clk;
  logic       reset_n;
  logic       key_press;
  logic [1:0] key_code;
  logic       key_clear;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       pw_ready;
  logic [1:0] digit_cnt;
  logic       key_overflow;

  typedef struct {
    string      name;
    logic [1:0] cnt;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       rdy;
    logic       ovf;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  parking_keypad_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_press   (key_press),
    .key_code    (key_code),
    .key_clear   (key_clear),
    .password_1  (password_1),
    .password_2  (password_2),
    .pw_ready    (pw_ready),
    .digit_cnt   (digit_cnt),
    .key_overflow(key_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, req);
  endtask

  function automatic void expect_ev(input string nm, input logic [1:0] c, input logic [1:0] p1,
                                    input logic [1:0] p2, input logic r, input logic o, input int cy);
    ev_t e;
    e.name = nm;
    e.cnt  = c;
    e.p1   = p1;
    e.p2   = p2;
    e.rdy  = r;
    e.ovf  = o;
    e.cyc  = cy;
    exp_q.push_back(e);
  endfunction

  task automatic start_press(input logic [1:0] code, output int first);
    key_code  = code;
    key_press = 1'b1;
    first     = cyc + 1;
  endtask

  // Monitor: any output change or overflow pulse is an event, matched against the queue head.
  logic [1:0] pc, pp1, pp2;
  logic       pr;
  ev_t        got;
  always @(negedge clk) begin
    if (!reset_n) begin
      pc = 2'd0; pp1 = 2'd0; pp2 = 2'd0; pr = 1'b0;
    end else begin
      if (digit_cnt !== pc || password_1 !== pp1 || password_2 !== pp2 ||
          pw_ready !== pr || key_overflow !== 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event @%0d: cnt=%0d p1=%0d p2=%0d rdy=%0b ovf=%0b, required no change",
                   cyc, digit_cnt, password_1, password_2, pw_ready, key_overflow);
        end else begin
          got = exp_q.pop_front();
          if (digit_cnt === got.cnt && password_1 === got.p1 && password_2 === got.p2 &&
              pw_ready === got.rdy && key_overflow === got.ovf && cyc == got.cyc) begin
            n_pass++;
          end else begin
            $display("FAIL %s: got cnt=%0d p1=%0d p2=%0d rdy=%0b ovf=%0b @%0d, required cnt=%0d p1=%0d p2=%0d rdy=%0b ovf=%0b @%0d",
                     got.name, digit_cnt, password_1, password_2, pw_ready, key_overflow, cyc,
                     got.cnt, got.p1, got.p2, got.rdy, got.ovf, got.cyc);
          end
        end
      end
      pc = digit_cnt; pp1 = password_1; pp2 = password_2; pr = pw_ready;
    end
  end

  int f;

  initial begin
    reset_n   = 1'b0;
    key_press = 1'b0;
    key_code  = 2'd0;
    key_clear = 1'b0;
    tick(3);
    check("rst_password_1", int'(password_1), 0);
    check("rst_password_2", int'(password_2), 0);
    check("rst_pw_ready", int'(pw_ready), 0);
    check("rst_digit_cnt", int'(digit_cnt), 0);
    check("rst_key_overflow", int'(key_overflow), 0);
    reset_n = 1'b1;
    tick(2);

    // first digit, clean press held 10 cycles
    start_press(2'd1, f);
    expect_ev("cap_first", 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, f + LAT);
    tick(10); key_press = 1'b0; tick(8);

    // second digit
    start_press(2'd2, f);
    expect_ev("cap_second", 2'd2, 2'd1, 2'd2, 1'b1, 1'b0, f + LAT);
    tick(10); key_press = 1'b0; tick(8);

    // third press rejected in READY
    start_press(2'd3, f);
    expect_ev("overflow", 2'd2, 2'd1, 2'd2, 1'b1, 1'b1, f + LAT);
    tick(10); key_press = 1'b0; tick(8);

    // clear from READY
    key_clear = 1'b1;
    expect_ev("clear_ready", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, cyc + 1);
    tick(1); key_clear = 1'b0; tick(3);

    // bouncing strobe: toggles every 2 cycles for 20 cycles, then held
    key_code = 2'd2;
    for (int i = 0; i < 5; i++) begin
      key_press = 1'b1; tick(2);
      key_press = 1'b0; tick(2);
    end
    start_press(2'd2, f);
    expect_ev("bounce_cap", 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, f + LAT);
    tick(10); key_press = 1'b0; tick(8);

    // clear lands on the same edge as an accepted press in GOT1; key stays held afterwards
    start_press(2'd3, f);
    tick(LAT);
    key_clear = 1'b1;
    expect_ev("clear_vs_press", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, f + LAT);
    tick(1); key_clear = 1'b0;
    tick(12); key_press = 1'b0; tick(8);

    // single digit then idle
    start_press(2'd1, f);
    expect_ev("cap_idle", 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, f + LAT);
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    expect_ev("timeout", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, f + LAT + TO);
    tick(10); key_press = 1'b0; tick(60);
`else
    tick(10); key_press = 1'b0; tick(60);
    check("no_timeout_cnt", int'(digit_cnt), 1);
    check("no_timeout_p1", int'(password_1), 1);
    key_clear = 1'b1;
    expect_ev("clear_got1", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, cyc + 1);
    tick(1); key_clear = 1'b0; tick(3);
`endif

    // fill with codes 3 and 0 (0 is a real digit)
    start_press(2'd3, f);
    expect_ev("cap_three", 2'd1, 2'd3, 2'd0, 1'b0, 1'b0, f + LAT);
    tick(10); key_press = 1'b0; tick(8);
    start_press(2'd0, f);
    expect_ev("cap_zero", 2'd2, 2'd3, 2'd0, 1'b1, 1'b0, f + LAT);
    tick(10); key_press = 1'b0; tick(8);

    // asynchronous reset between edges in READY
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_password_1", int'(password_1), 0);
    check("async_password_2", int'(password_2), 0);
    check("async_pw_ready", int'(pw_ready), 0);
    check("async_digit_cnt", int'(digit_cnt), 0);
    check("async_key_overflow", int'(key_overflow), 0);

    // key held across reset release counts as a fresh press
    key_press = 1'b1;
    key_code  = 2'd2;
    tick(3);
    reset_n = 1'b1;
    f = cyc + 1;
    expect_ev("held_over_reset", 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, f + LAT);
    tick(10); key_press = 1'b0;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_keypad_entry.md
PARKING_KEYPAD_ENTRY -- requirements
Module: parking_keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a key level change (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles after the last accepted digit before the entry is discarded (used only with TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port key_press  input  1  raw asynchronous keypad strobe; high while a key is held.
REQ-006 SHALL have port key_code  input  2  raw digit value; source holds it stable while key_press is high.
REQ-007 SHALL have port key_clear  input  1  synchronous clear request, single-cycle pulse.
REQ-008 SHALL have port password_1  output  2  first captured digit, fed to the parking controller.
REQ-009 SHALL have port password_2  output  2  second captured digit, fed to the parking controller.
REQ-010 SHALL have port pw_ready  output  1  high while both digits are held.
REQ-011 SHALL have port digit_cnt  output  2  digits captured so far (0, 1 or 2).
REQ-012 SHALL have port key_overflow  output  1  one-cycle pulse when a press is rejected in READY.

Function
REQ-013 SHALL pass key_press and key_code each through a 2-flop synchronizer before any use.
REQ-014 SHALL update the debounced key level only after the synchronized key_press holds a new value for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 SHALL treat a 0->1 transition of the debounced level as an accepted press and sample synchronized key_code in the same cycle; releases produce no event.
REQ-016 SHALL show a capture on outputs at the (3 + DEBOUNCE_CYCLES)th rising clk edge after the first edge that samples raw key_press high, given a bounce-free press.
REQ-017 SHALL implement FSM states IDLE (digit_cnt=0), GOT1 (digit_cnt=1) and READY (digit_cnt=2).
REQ-018 SHALL, on an accepted press in IDLE, load password_1 with the code and go to GOT1.
REQ-019 SHALL, on an accepted press in GOT1, load password_2 with the code and go to READY.
REQ-020 SHALL hold password_1/password_2 in READY, ignore further presses and pulse key_overflow for one cycle per rejected press.
REQ-021 SHALL drive pw_ready high exactly while in READY.
REQ-022 SHALL, on key_clear in any state, go to IDLE next cycle with password_1, password_2, digit_cnt = 0.
REQ-023 SHALL give key_clear priority over an accepted press in the same cycle; that press is dropped and key_overflow stays 0.
REQ-024 SHALL leave debounce state unaffected by key_clear, so a key still held after a clear produces no new press until released and re-pressed.
REQ-025 SHALL treat code 0 as a valid digit; emptiness is indicated only by digit_cnt and pw_ready.

Reset
REQ-026 SHALL, while reset_n is low, force IDLE, password_1 = 0, password_2 = 0, pw_ready = 0, digit_cnt = 0, key_overflow = 0, synchronizers, debounced level and all counters to 0.
REQ-027 SHALL, on reset mid-entry, discard any partial digit; a key held across reset release counts as a new press once debounced.

Configuration
REQ-028 SHALL, with macro PARKING_KEYPAD_TIMEOUT_EN defined, run a counter in GOT1 and READY that restarts on each accepted press and returns to IDLE, clearing outputs as in REQ-022, when it reaches TIMEOUT_CYCLES.
REQ-029 SHALL, without PARKING_KEYPAD_TIMEOUT_EN, omit the timeout counter entirely and leave GOT1/READY only via key_clear or reset.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-030 SHALL cover: release reset, hold key_press=1 with key_code=1 for 10 cycles -> password_1=1, digit_cnt=1 at the 7th edge, pw_ready=0.
REQ-031 SHALL cover: second clean press with key_code=2 -> password_2=2, digit_cnt=2, pw_ready=1; a third press -> key_overflow 1-cycle pulse, outputs unchanged.
REQ-032 SHALL cover: key_press toggled every 2 cycles for 20 cycles then held -> exactly one capture, none during the bounce.
REQ-033 SHALL cover: key_clear coincident with an accepted press in GOT1 -> IDLE, password_1=0, no capture, key_overflow=0.
REQ-034 SHALL cover: with PARKING_KEYPAD_TIMEOUT_EN, one digit then 50 idle cycles -> IDLE, digit_cnt=0; without it, state stays GOT1 indefinitely.
REQ-035 SHALL cover: reset_n pulsed low in READY asynchronously (between edges) -> all outputs 0 immediately, before the next clk edge.
